counter_sched: RTL and testbench

- Round-robin scheduler that shares one enable-driven counter among NREQ requesters.
- Each requester asks for a run window of programmable length. The scheduler grants one requester at a time and drives the counter's en for exactly that many cycles.
- Signals completion per requester.
- Sits between requester logic and the counter1 instance, whose en input it drives.

---
 rtl/counter_sched_pkg.sv | 14 +
 rtl/counter_sched_rr_arb.sv | 36 +++
 rtl/counter_sched.sv | 103 ++++++++++
 tb/tb_counter_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter scheduler.
// State encoding and default parameter values.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/counter_sched_rr_arb.sv
// Round-robin arbiter for the counter scheduler.
// Searches req from ptr upward with wrap; first set bit wins.
module rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx
);

  logic             found;
  logic [IDX_W-1:0] k;
  int               s;

  // Scan NREQ positions starting at ptr, keep the first hit.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    k       = '0;
    s       = 0;
    for (int i = 0; i < NREQ; i++) begin
      s = int'(ptr) + i;
      if (s >= NREQ) s = s - NREQ;
      k = IDX_W'(s);
      if (!found && req[k]) begin
        found      = 1'b1;
        win[k]     = 1'b1;
        win_idx    = k;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one enable-driven counter.
// Grants one requester a run window of its latched length.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  output logic                  en_out,
  output logic [NREQ-1:0]       gnt,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      remain
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [NREQ-1:0]  win;
  logic [IDX_W-1:0] win_idx;
  logic [CNT_W-1:0] len_w;
  logic             req_w;
  logic             last;
  logic [IDX_W-1:0] nxt_ptr;

  rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // Pick the winner's run length out of the packed len bus.
  always_comb begin
    len_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) len_w = len[i*CNT_W +: CNT_W];
    end
  end

  assign req_w   = |(req & gnt);
  assign last    = remain < CNT_W'(2);
  assign nxt_ptr = (gnt_idx == IDX_W'(NREQ-1)) ?
                   '0 : gnt_idx + 1'b1;

  // Scheduler FSM with registered outputs and run-length counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      en_out  <= 1'b0;
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      done    <= '0;
      aborted <= 1'b0;
      remain  <= '0;
    end else begin
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            state   <= ST_RUN;
            gnt     <= win;
            gnt_idx <= win_idx;
            busy    <= 1'b1;
            remain  <= len_w;
            en_out  <= |len_w;
          end
        end
        ST_RUN: begin
          if (!req_w || last) begin
            state   <= ST_DONE;
            en_out  <= 1'b0;
            gnt     <= '0;
            remain  <= '0;
            done    <= gnt;
            aborted <= !req_w;
            ptr     <= nxt_ptr;
          end else begin
            remain <= remain - 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          aborted <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched.
// Directed scenarios then random traffic against a cycle model.
module tb_counter_sched;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [31:0]       len;
  logic              en_out;
  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic              aborted;
  logic [CNT_W-1:0]  remain;

  int n_chk  = 0;
  int n_fail = 0;

  int m_phase = 0;
  int m_w     = 0;
  int m_left  = 0;
  int m_ptr   = 0;
  int m_gidx  = 0;
  bit m_ab    = 0;

  int en_cnt   = 0;
  int last_idx = 0;
  bit last_ab  = 0;
  int done_q[$];

  always #5 clk = ~clk;

  counter_sched #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .len     (len),
    .en_out  (en_out),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .remain  (remain)
  );

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int lenof(int i);
    logic [31:0] v;
    v = len >> (i * CNT_W);
    return int'(v[7:0]);
  endfunction

  // Spec-level model: one step per rising edge.
  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_gidx = 0;
      m_ab = 0; m_left = 0; m_w = 0;
      return;
    end
    case (m_phase)
      0: if (req != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (req[c]) begin
            m_w = c;
            break;
          end
        end
        m_gidx  = m_w;
        m_left  = lenof(m_w);
        m_phase = 1;
      end
      1: begin
        if (!req[m_w]) begin
          m_phase = 2; m_ab = 1;
          m_ptr = (m_w + 1) % NREQ;
        end else if (m_left <= 1) begin
          m_phase = 2; m_ab = 0;
          m_ptr = (m_w + 1) % NREQ;
        end else begin
          m_left--;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic cyc();
    logic [31:0] e_gnt, e_done;
    @(posedge clk);
    model_step();
    #1;
    e_gnt  = (m_phase == 1) ? (32'd1 << m_w) : 32'd0;
    e_done = (m_phase == 2) ? (32'd1 << m_w) : 32'd0;
    check("en_out", 32'(en_out),
          32'(m_phase == 1 && m_left > 0));
    check("gnt", 32'(gnt), e_gnt);
    check("gnt_idx", 32'(gnt_idx), 32'(m_gidx));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("done", 32'(done), e_done);
    check("aborted", 32'(aborted),
          32'(m_phase == 2 && m_ab));
    check("remain", 32'(remain),
          (m_phase == 1) ? 32'(m_left) : 32'd0);
    if (en_out === 1'b1) en_cnt++;
    if (done !== '0) begin
      for (int i = 0; i < NREQ; i++)
        if (done[i]) last_idx = i;
      last_ab = aborted;
      done_q.push_back(last_idx);
    end
  endtask

  task automatic run_until_done(int maxc, string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cyc();
      if (done !== '0) seen = 1;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_en(int n, int maxc, string tag);
    for (int i = 0; i < maxc && en_cnt < n; i++) cyc();
    check({tag, "_en_wait"}, en_cnt, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = '0;
    len   = '0;

    // reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    check("idle_en_cnt", en_cnt, 0);
    check("idle_done_cnt", done_q.size(), 0);

    // single run, length 5
    len = 32'd5;
    req = 4'b0001;
    en_cnt = 0;
    run_until_done(12, "single");
    check("single_en_cnt", en_cnt, 5);
    check("single_idx", last_idx, 0);
    check("single_ab", 32'(last_ab), 32'd0);
    req = '0;
    cyc(); cyc();

    // round robin with all lengths 2
    do_reset();
    len = 32'h02020202;
    req = 4'b1111;
    done_q.delete();
    for (int r = 0; r < 5; r++) run_until_done(20, "rr");
    req = '0;
    cyc(); cyc();
    check("rr_count", done_q.size(), 5);
    for (int r = 0; r < 5 && r < done_q.size(); r++)
      check("rr_order", done_q[r], exp_order[r]);

    // zero length
    len = 32'h0;
    req = 4'b0100;
    en_cnt = 0;
    run_until_done(10, "zero");
    check("zero_en_cnt", en_cnt, 0);
    check("zero_idx", last_idx, 2);
    check("zero_ab", 32'(last_ab), 32'd0);
    req = '0;
    cyc(); cyc();

    // abort after 3rd enable cycle, req[2] pending
    len = 32'h00000A00;
    req = 4'b0110;
    en_cnt = 0;
    wait_en(3, 10, "abort");
    req[1] = 1'b0;
    run_until_done(10, "abort");
    check("abort_en_cnt", en_cnt, 3);
    check("abort_idx", last_idx, 1);
    check("abort_ab", 32'(last_ab), 32'd1);
    run_until_done(10, "after_abort");
    check("after_abort_idx", last_idx, 2);
    req = '0;
    cyc(); cyc();

    // reset mid-run, then full rerun
    len = 32'd20;
    req = 4'b0001;
    en_cnt = 0;
    wait_en(4, 10, "midrst");
    rst_n = 1'b0;
    done_q.delete();
    cyc();
    check("midrst_en", 32'(en_out), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_nodone", done_q.size(), 0);
    rst_n = 1'b1;
    en_cnt = 0;
    run_until_done(40, "rerun");
    check("rerun_en_cnt", en_cnt, 20);
    check("rerun_idx", last_idx, 0);
    req = '0;
    cyc(); cyc();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            len[i*8 +: 8] = ($urandom_range(0, 29) == 0) ?
              8'd255 : 8'($urandom_range(0, 6));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        int j;
        j = int'($urandom_range(0, 3));
        len[j*8 +: 8] = 8'($urandom);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
